// File: rtl/ysyx_2022040010_mul_seq.sv
// Multi-cycle RV64M shift-add multiplier (MUL/MULH/MULHU/MULW) that borrows the EXU's shared adder.
// Optional `MULW_HALF_ITER_EN: MULW stops after 32 iterations and takes its result from lo[63:32].
module ysyx_2022040010_mul_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic [XLEN-1:0] add_a,
    output logic [XLEN-1:0] add_b,
    output logic            add_cin,
    output logic            add_alu32,
    input  logic [XLEN-1:0] add_s,
    input  logic            add_cout
);

    typedef enum logic [2:0] {
        S_IDLE, S_NEGA, S_NEGB, S_MUL, S_NEGLO, S_NEGHI, S_DONE
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULH  = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b10;
    localparam logic [1:0] OP_MULW  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST_FULL = CNT_W'(XLEN - 1);
`ifdef MULW_HALF_ITER_EN
    localparam logic [CNT_W-1:0] CNT_LAST_W = CNT_W'(XLEN/2 - 1);
`else
    localparam logic [CNT_W-1:0] CNT_LAST_W = CNT_W'(XLEN - 1);
`endif

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   mcand_reg, mcand_next;
    logic [XLEN-1:0]   hi_reg, hi_next;
    logic [XLEN-1:0]   lo_reg, lo_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              neg_reg, neg_next;
    logic              carry_reg, carry_next;
    logic [1:0]        op_reg, op_next;
    logic [XLEN-1:0]   result_reg, result_next;
    logic [2*XLEN:0]   step_sum;
    logic [XLEN-1:0]   mulw_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            mcand_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            op_reg     <= OP_MUL;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            carry_reg  <= carry_next;
            op_reg     <= op_next;
            result_reg <= result_next;
        end
    end

    // One shift-add step: the new partial sum (with carry) drops its LSB into the multiplier register.
    assign step_sum = {add_cout, add_s, lo_reg};

`ifdef MULW_HALF_ITER_EN
    assign mulw_word = {{(XLEN-32){lo_next[XLEN-1]}}, lo_next[XLEN-1:XLEN-32]};
`else
    assign mulw_word = {{(XLEN-32){lo_next[31]}}, lo_next[31:0]};
`endif

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        carry_next  = carry_reg;
        op_next     = op_reg;
        result_next = result_reg;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_next = in_a;
                    lo_next    = in_b;
                    hi_next    = '0;
                    cnt_next   = '0;
                    op_next    = in_op;
                    neg_next   = (in_op == OP_MULH) && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                    if (in_op == OP_MULH && in_a[XLEN-1])
                        state_next = S_NEGA;
                    else if (in_op == OP_MULH && in_b[XLEN-1])
                        state_next = S_NEGB;
                    else
                        state_next = S_MUL;
                end
            end
            S_NEGA: begin
                add_a      = ~mcand_reg;
                add_cin    = 1'b1;
                mcand_next = add_s;
                // lo still holds the untouched multiplier, so its MSB is rs2's sign
                state_next = (op_reg == OP_MULH && lo_reg[XLEN-1]) ? S_NEGB : S_MUL;
            end
            S_NEGB: begin
                add_a      = ~lo_reg;
                add_cin    = 1'b1;
                lo_next    = add_s;
                state_next = S_MUL;
            end
            S_MUL: begin
                add_a    = hi_reg;
                add_b    = lo_reg[0] ? mcand_reg : '0;
                hi_next  = step_sum[2*XLEN:XLEN+1];
                lo_next  = step_sum[XLEN:1];
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ((op_reg == OP_MULW) ? CNT_LAST_W : CNT_LAST_FULL))
                    state_next = neg_reg ? S_NEGLO : S_DONE;
            end
            S_NEGLO: begin
                add_a      = ~lo_reg;
                add_cin    = 1'b1;
                lo_next    = add_s;
                carry_next = add_cout;
                state_next = S_NEGHI;
            end
            S_NEGHI: begin
                add_a      = ~hi_reg;
                add_cin    = carry_reg;
                hi_next    = add_s;
                state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (flush)
            state_next = S_IDLE;

        // Result is captured only on entry to DONE, so a flushed op never updates it
        if (state_next == S_DONE && state_reg != S_DONE) begin
            case (op_reg)
                OP_MUL:   result_next = lo_next;
                OP_MULH,
                OP_MULHU: result_next = hi_next;
                default:  result_next = mulw_word;
            endcase
        end
    end

    assign in_ready   = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign out_result = result_reg;
    assign add_alu32  = 1'b0;

endmodule

// File: tb/tb_ysyx_2022040010_mul_seq.sv
// Self-checking bench for ysyx_2022040010_mul_seq: vector table, scoreboard queue, flush/reset corner cases.
// Honours `MULW_HALF_ITER_EN for the expected MULW latency and result.
module tb_ysyx_2022040010_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_cin;
    logic        add_alu32;
    logic [63:0] add_s;
    logic        add_cout;
    logic [64:0] add_full;

    always #5 clk = ~clk;

    // Behavioural stand-in for the EXU's shared adder
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {64'b0, add_cin};
    assign add_s    = add_full[63:0];
    assign add_cout = add_full[64];

    ysyx_2022040010_mul_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_alu32(add_alu32),
        .add_s(add_s), .add_cout(add_cout)
    );

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef MULW_HALF_ITER_EN
    localparam int MULW_ITERS = 32;
`else
    localparam int MULW_ITERS = 64;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        case (op)
            2'b00: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            2'b01: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            2'b10: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            default: begin p = {64'b0, a} * {64'b0, b}; return {{32{p[31]}}, p[31:0]}; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        int k = 0;
        if (op == 2'b01) begin
            k = int'(a[63]) + int'(b[63]) + ((a[63] ^ b[63]) ? 2 : 0);
        end
        return ((op == 2'b11) ? MULW_ITERS : 64) + k;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] res, input int hold);
        int   edges;
        logic ready_seen;
        exp_t e;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back('{res, exp_lat(op, a, b)});
        edges = 0;
        ready_seen = 1'b0;
        while (!out_valid && edges < 300) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        e = sb.pop_front();
        check("in_ready_low_busy", ready_seen, 1'b0);
        check("out_valid_timeout", out_valid, 1'b1);
        check("latency", edges, e.lat);
        check("result", out_result, e.res);
        $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, out_result, edges);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", out_result, e.res);
            check("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("ready_back", in_ready, 1'b1);
        check("add_a_idle", add_a, 64'd0);
    endtask

    vec_t vecs[14];
    logic seen;
    int   waited;

    initial begin
        vecs[0]  = '{2'b00, 64'd3, 64'd5, 64'd15};
        vecs[1]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0};
        vecs[4]  = '{2'b11, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[6]  = '{2'b00, 64'd0, 64'h1234_5678_9ABC_DEF0, 64'd0};
        vecs[7]  = '{2'b00, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0};
        vecs[8]  = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[10] = '{2'b10, 64'h8000_0000_0000_0000, 64'd2, 64'd1};
        vecs[11] = '{2'b01, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[12] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[13] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};

        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_add_a", add_a, 64'd0);
        check("rst_add_b", add_b, 64'd0);
        check("rst_add_cin", add_cin, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, (i == 0) ? 5 : 0);

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            op = 2'($urandom_range(3, 0));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            run_op(op, a, b, model(op, a, b), 0);
        end

        // Flush during the 10th multiply iteration
        @(negedge clk);
        in_op = 2'b00; in_a = 64'd123; in_b = 64'd456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_busy", busy, 1'b0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_result", seen, 1'b0);
        run_op(2'b00, 64'd7, 64'd6, 64'd42, 0);

        // Flush in the same cycle as the accept drops the request
        @(negedge clk);
        in_op = 2'b00; in_a = 64'd9; in_b = 64'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_busy", busy, 1'b0);
        check("flush_accept_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_accept_no_result", seen, 1'b0);

        // Flush together with out_ready while the result is waiting
        @(negedge clk);
        in_op = 2'b00; in_a = 64'd2; in_b = 64'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check("flush_done_reached", out_valid, 1'b1);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_valid", out_valid, 1'b0);
        check("flush_done_ready", in_ready, 1'b1);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_op = 2'b00; in_a = 64'd11; in_b = 64'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy", busy, 1'b1);
        check("mid_alu32", add_alu32, 1'b0);
        check("mid_cin", add_cin, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_result", out_result, 64'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_add_a", add_a, 64'd0);
        check("midrst_add_b", add_b, 64'd0);
        check("midrst_add_cin", add_cin, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
